// File: rtl/pipe_cond_control.sv
// Pipelined control unit: Decode-stage decoder, D->E / E->M / M->W control
// registers, condition-code evaluation against a registered NZCV flag set,
// and branch-taken resolution in Execute.
module pipe_cond_control #(
    parameter bit         COND_EN       = 1'b1,
    parameter bit         REG_OFFSET_EN = 1'b1,
    parameter logic [3:0] FLAGS_RESET   = 4'b0000
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [31:0] InstrD,
    input  logic [3:0]  ALUFlagsE,
    input  logic        FlushE,
    output logic [1:0]  ImmSrcD,
    output logic [1:0]  RegSrcD,
    output logic        ALUSrcE,
    output logic [3:0]  ALUControlE,
    output logic        BranchTakenE,
    output logic        RegWriteM,
    output logic        MemWriteM,
    output logic        MemtoRegM,
    output logic        RegWriteW,
    output logic        MemtoRegW,
    output logic [3:0]  FlagsQ,
    output logic        UndefD
);

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0010;
    localparam logic [3:0] ALU_ADD = 4'b0100;
    localparam logic [3:0] ALU_ORR = 4'b1100;
    localparam logic [3:0] ALU_MOV = 4'b1101;
    localparam logic [3:0] ALU_CMP = 4'b1010;

    // Control bundle carried from Decode into Execute
    typedef struct packed {
        logic       reg_write;
        logic       mem_write;
        logic       mem_to_reg;
        logic       alu_src;
        logic [3:0] alu_control;
        logic       branch;
        logic [1:0] flag_write;   // [1] = N,Z  [0] = C,V
    } ctrl_t;

    ctrl_t       ctrl_d, ctrl_e;
    logic [3:0]  cond_e;
    logic        cond_ex;
    logic [1:0]  op;
    logic [5:0]  funct;
    logic [3:0]  cmd;
    logic        undef;
    logic [1:0]  imm_src;
    logic [1:0]  reg_src;
    logic [3:0]  flags_q;
    logic        reg_write_m, mem_write_m, mem_to_reg_m;
    logic        reg_write_w, mem_to_reg_w;
    logic        flag_n, flag_z, flag_c, flag_v;

    // Register numbers in the low nibble are not needed by the control path
    logic unused_bits;
    assign unused_bits = ^InstrD[3:0];

    assign op    = InstrD[27:26];
    assign funct = InstrD[25:20];
    assign cmd   = funct[4:1];

    // Decode: undefined encodings leave every enable at zero
    always_comb begin
        ctrl_d  = '0;
        imm_src = 2'b00;
        reg_src = 2'b00;
        undef   = 1'b0;
        case (op)
            2'b00: begin
                if (InstrD[27:4] == 24'h12FFF1) begin
                    // BX: branch to Rm through the MOV path
                    ctrl_d.branch      = 1'b1;
                    ctrl_d.alu_control = ALU_MOV;
                end else begin
                    case (cmd)
                        ALU_ADD, ALU_SUB, ALU_AND, ALU_ORR, ALU_MOV: begin
                            ctrl_d.reg_write   = 1'b1;
                            ctrl_d.alu_control = cmd;
                            ctrl_d.alu_src     = funct[5];
                            if (funct[0])
                                ctrl_d.flag_write = (cmd == ALU_ADD || cmd == ALU_SUB) ? 2'b11 : 2'b10;
                        end
                        ALU_CMP: begin
                            ctrl_d.alu_control = ALU_SUB;
                            ctrl_d.alu_src     = funct[5];
                            ctrl_d.flag_write  = 2'b11;
                        end
                        default: undef = 1'b1;
                    endcase
                end
            end
            2'b01: begin
                imm_src            = 2'b01;
                ctrl_d.alu_src     = ~funct[5];
                ctrl_d.alu_control = funct[3] ? ALU_ADD : ALU_SUB;
                if (funct[5] && !REG_OFFSET_EN) begin
                    undef = 1'b1;
                    ctrl_d.alu_src = 1'b0;
                end else if (funct[0]) begin
                    ctrl_d.reg_write  = 1'b1;
                    ctrl_d.mem_to_reg = 1'b1;
                end else begin
                    ctrl_d.mem_write = 1'b1;
                    reg_src[1]       = 1'b1;
                end
            end
            2'b10: begin
                imm_src            = 2'b10;
                reg_src[0]         = 1'b1;
                ctrl_d.branch      = 1'b1;
                ctrl_d.alu_src     = 1'b1;
                ctrl_d.alu_control = ALU_ADD;
                ctrl_d.reg_write   = InstrD[24];
            end
            default: undef = 1'b1;
        endcase
    end

    // D->E register; reset and flush both insert an all-zero bubble
    always_ff @(posedge CLK) begin
        if (RESET) begin
            ctrl_e <= '0;
            cond_e <= 4'b0000;
        end else if (FlushE) begin
            ctrl_e <= '0;
            cond_e <= InstrD[31:28];
        end else begin
            ctrl_e <= ctrl_d;
            cond_e <= InstrD[31:28];
        end
    end

    assign {flag_n, flag_z, flag_c, flag_v} = flags_q;

    // Condition check against the registered flags
    always_comb begin
        cond_ex = 1'b0;
        case (cond_e)
            4'b0000: cond_ex = flag_z;
            4'b0001: cond_ex = ~flag_z;
            4'b0010: cond_ex = flag_c;
            4'b0011: cond_ex = ~flag_c;
            4'b0100: cond_ex = flag_n;
            4'b0101: cond_ex = ~flag_n;
            4'b0110: cond_ex = flag_v;
            4'b0111: cond_ex = ~flag_v;
            4'b1000: cond_ex = flag_c & ~flag_z;
            4'b1001: cond_ex = ~flag_c | flag_z;
            4'b1010: cond_ex = (flag_n == flag_v);
            4'b1011: cond_ex = (flag_n != flag_v);
            4'b1100: cond_ex = ~flag_z & (flag_n == flag_v);
            4'b1101: cond_ex = flag_z | (flag_n != flag_v);
            4'b1110: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
        if (!COND_EN)
            cond_ex = 1'b1;
    end

    // NZCV register; N,Z and C,V update independently
    always_ff @(posedge CLK) begin
        if (RESET) begin
            flags_q <= FLAGS_RESET;
        end else begin
            if (ctrl_e.flag_write[1] && cond_ex)
                flags_q[3:2] <= ALUFlagsE[3:2];
            if (ctrl_e.flag_write[0] && cond_ex)
                flags_q[1:0] <= ALUFlagsE[1:0];
        end
    end

    // E->M register; writes are squashed when the condition fails
    always_ff @(posedge CLK) begin
        if (RESET) begin
            reg_write_m  <= 1'b0;
            mem_write_m  <= 1'b0;
            mem_to_reg_m <= 1'b0;
        end else begin
            reg_write_m  <= ctrl_e.reg_write & cond_ex;
            mem_write_m  <= ctrl_e.mem_write & cond_ex;
            mem_to_reg_m <= ctrl_e.mem_to_reg;
        end
    end

    // M->W register
    always_ff @(posedge CLK) begin
        if (RESET) begin
            reg_write_w  <= 1'b0;
            mem_to_reg_w <= 1'b0;
        end else begin
            reg_write_w  <= reg_write_m;
            mem_to_reg_w <= mem_to_reg_m;
        end
    end

    assign ImmSrcD      = imm_src;
    assign RegSrcD      = reg_src;
    assign UndefD       = undef;
    assign ALUSrcE      = ctrl_e.alu_src;
    assign ALUControlE  = ctrl_e.alu_control;
    assign BranchTakenE = ctrl_e.branch & cond_ex;
    assign RegWriteM    = reg_write_m;
    assign MemWriteM    = mem_write_m;
    assign MemtoRegM    = mem_to_reg_m;
    assign RegWriteW    = reg_write_w;
    assign MemtoRegW    = mem_to_reg_w;
    assign FlagsQ       = flags_q;

endmodule

// File: tb/tb_pipe_cond_control.sv
// Directed bench for pipe_cond_control: hand-encoded instruction stream with
// hand-computed control/flag expectations; a second instance has register
// offsets disabled.
module tb_pipe_cond_control;

    localparam logic [31:0] CMP5   = 32'hE3510005; // CMP R1,#5
    localparam logic [31:0] BEQ    = 32'h0A000002;
    localparam logic [31:0] BNE    = 32'h1A000002;
    localparam logic [31:0] ADDS   = 32'hE0910002; // ADDS R0,R1,R2
    localparam logic [31:0] ANDS   = 32'hE0110002; // ANDS R0,R1,R2
    localparam logic [31:0] ADDNES = 32'h12900001; // ADDNES R0,R0,#1
    localparam logic [31:0] BL     = 32'hEB000000;
    localparam logic [31:0] LDRR   = 32'hE7132004; // LDR R2,[R3,-R4]
    localparam logic [31:0] STRI   = 32'hE5821004; // STR R1,[R2,#4]
    localparam logic [31:0] BX     = 32'hE12FFF13; // BX R3
    localparam logic [31:0] BUB    = 32'hEC000000; // op=11, undefined

    logic        CLK = 1'b0;
    logic        RESET;
    logic [31:0] InstrD;
    logic [3:0]  ALUFlagsE;
    logic        FlushE;

    logic [1:0] ImmSrcD, RegSrcD;
    logic       ALUSrcE, BranchTakenE, RegWriteM, MemWriteM, MemtoRegM;
    logic       RegWriteW, MemtoRegW, UndefD;
    logic [3:0] ALUControlE, FlagsQ;

    logic [1:0] ImmSrcD2, RegSrcD2;
    logic       ALUSrcE2, BranchTakenE2, RegWriteM2, MemWriteM2, MemtoRegM2;
    logic       RegWriteW2, MemtoRegW2, UndefD2;
    logic [3:0] ALUControlE2, FlagsQ2;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 CLK = ~CLK;

    pipe_cond_control dut (
        .CLK(CLK), .RESET(RESET), .InstrD(InstrD), .ALUFlagsE(ALUFlagsE), .FlushE(FlushE),
        .ImmSrcD(ImmSrcD), .RegSrcD(RegSrcD), .ALUSrcE(ALUSrcE), .ALUControlE(ALUControlE),
        .BranchTakenE(BranchTakenE), .RegWriteM(RegWriteM), .MemWriteM(MemWriteM),
        .MemtoRegM(MemtoRegM), .RegWriteW(RegWriteW), .MemtoRegW(MemtoRegW),
        .FlagsQ(FlagsQ), .UndefD(UndefD)
    );

    pipe_cond_control #(.REG_OFFSET_EN(1'b0)) dut_noreg (
        .CLK(CLK), .RESET(RESET), .InstrD(InstrD), .ALUFlagsE(ALUFlagsE), .FlushE(FlushE),
        .ImmSrcD(ImmSrcD2), .RegSrcD(RegSrcD2), .ALUSrcE(ALUSrcE2), .ALUControlE(ALUControlE2),
        .BranchTakenE(BranchTakenE2), .RegWriteM(RegWriteM2), .MemWriteM(MemWriteM2),
        .MemtoRegM(MemtoRegM2), .RegWriteW(RegWriteW2), .MemtoRegW(MemtoRegW2),
        .FlagsQ(FlagsQ2), .UndefD(UndefD2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Advance one cycle, then present the next Decode-stage inputs
    task automatic next(input logic [31:0] instr, input logic [3:0] flags, input logic flush);
        @(posedge CLK);
        #1;
        InstrD    = instr;
        ALUFlagsE = flags;
        FlushE    = flush;
        #1;
    endtask

    initial begin
        RESET = 1'b1; InstrD = BUB; ALUFlagsE = 4'h0; FlushE = 1'b0;
        next(BUB, 4'h0, 1'b0);
        next(BUB, 4'h0, 1'b0);
        chk("rst_flags", FlagsQ, 4'b0000);
        chk("rst_ctrl", {ALUSrcE, ALUControlE, BranchTakenE, RegWriteM, MemWriteM,
                         MemtoRegM, RegWriteW, MemtoRegW}, 0);
        RESET = 1'b0;

        next(CMP5, 4'h0, 1'b0);
        chk("cmp_dec", {ImmSrcD, RegSrcD, UndefD}, {2'b00, 2'b00, 1'b0});
        next(BEQ, 4'b0100, 1'b0);
        chk("cmp_aluctl", ALUControlE, 4'b0010);
        chk("cmp_alusrc", ALUSrcE, 1'b1);
        chk("b_dec", {ImmSrcD, RegSrcD}, {2'b10, 2'b01});
        next(BNE, 4'h0, 1'b0);
        chk("cmp_flags", FlagsQ, 4'b0100);
        chk("beq_taken", BranchTakenE, 1'b1);
        next(ADDS, 4'h0, 1'b0);
        chk("bne_taken", BranchTakenE, 1'b0);
        chk("beq_regwm", RegWriteM, 1'b0);

        next(ANDS, 4'b1011, 1'b0);
        next(ADDNES, 4'b0100, 1'b0);
        chk("adds_flags", FlagsQ, 4'b1011);
        next(BL, 4'b1000, 1'b0);
        chk("ands_flags", FlagsQ, 4'b0111);
        next(LDRR, 4'h0, 1'b0);
        chk("addne_regwm", RegWriteM, 1'b0);
        chk("addne_flags", FlagsQ, 4'b0111);
        chk("bl_taken", BranchTakenE, 1'b1);
        chk("ldr_undef", UndefD, 1'b0);
        chk("ldr_noreg_undef", UndefD2, 1'b1);
        next(STRI, 4'h0, 1'b1);
        chk("bl_regwm", RegWriteM, 1'b1);
        chk("ldr_alusrc", ALUSrcE, 1'b0);
        chk("ldr_aluctl", ALUControlE, 4'b0010);
        chk("str_dec", {ImmSrcD, RegSrcD}, {2'b01, 2'b10});
        next(BUB, 4'h0, 1'b0);
        chk("bl_regww", {RegWriteW, MemtoRegW}, 2'b10);
        chk("ldr_m", {RegWriteM, MemtoRegM}, 2'b11);
        chk("flush_aluctl", ALUControlE, 4'b0000);
        chk("op11_undef", UndefD, 1'b1);
        next(STRI, 4'h0, 1'b0);
        chk("ldr_w", {RegWriteW, MemtoRegW}, 2'b11);
        chk("ldr_noreg_w", RegWriteW2, 1'b0);
        chk("flush_memwm", MemWriteM, 1'b0);
        next(BL, 4'h0, 1'b0);
        chk("str_e", {ALUSrcE, ALUControlE}, {1'b1, 4'b0100});
        next(ADDS, 4'h0, 1'b0);
        chk("str_m", {MemWriteM, RegWriteM}, 2'b10);

        next(LDRR, 4'b1111, 1'b0);
        chk("pre_rst_regwm", RegWriteM, 1'b1);
        RESET = 1'b1;
        next(BUB, 4'h0, 1'b0);
        next(BUB, 4'h0, 1'b0);
        RESET = 1'b0;
        chk("rst2_flags", FlagsQ, 4'b0000);
        chk("rst2_ctrl", {ALUSrcE, ALUControlE, BranchTakenE, RegWriteM, MemWriteM,
                          MemtoRegM, RegWriteW, MemtoRegW}, 0);
        next(BX, 4'h0, 1'b0);
        chk("rst2_regww", RegWriteW, 1'b0);
        chk("bx_dec", {RegSrcD, UndefD}, {2'b00, 1'b0});
        next(BUB, 4'h0, 1'b0);
        chk("bx_e", {BranchTakenE, ALUControlE, ALUSrcE}, {1'b1, 4'b1101, 1'b0});
        chk("rst2_regww2", RegWriteW, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/pipe_cond_control.md
Name: pipe_cond_control

Overview:
- Next-generation control unit for the pipelined processor.
- Combines the Decode-stage instruction decoder with registered control pipelines for the D->E, E->M and M->W stages.
- Adds ARM condition-code evaluation against an internal NZCV flag register, and applies branch-taken gating in Execute.
- Adds register-offset and down-offset (U=0) memory addressing, an undefined-instruction flag, and an Execute-stage flush.

Parameters:
- COND_EN, 1: when 1, Instr[31:28] is evaluated; when 0, every instruction executes unconditionally.
- REG_OFFSET_EN, 1: when 1, LDR/STR with Funct[5]=1 use a register offset; when 0, that encoding is undefined.
- FLAGS_RESET, 4'b0000: NZCV value loaded on reset.

Ports:
- CLK  in  1  clock, rising edge.
- RESET  in  1  synchronous, active-high reset.
- InstrD  in  32  Decode-stage instruction.
- ALUFlagsE  in  4  {N,Z,C,V} from the ALU in Execute.
- FlushE  in  1  clears the D->E control register at the next edge.
- ImmSrcD  out  2  extend select, combinational.
- RegSrcD  out  2  register-address select, combinational.
- ALUSrcE  out  1  ALU B-operand select (1 = immediate).
- ALUControlE  out  4  ALU operation.
- BranchTakenE  out  1  branch resolved taken in Execute.
- RegWriteM, MemWriteM, MemtoRegM  out  1 each  Memory-stage controls.
- RegWriteW, MemtoRegW  out  1 each  Writeback-stage controls.
- FlagsQ  out  4  current NZCV register.
- UndefD  out  1  undefined instruction in Decode, combinational.

Behaviour:
- Clock and reset: one clock, CLK. RESET is synchronous and active-high.
- Reset state:
  - Every registered control output is 0, and FlagsQ = FLAGS_RESET.
  - Reset clears every stage, so an instruction in flight is discarded.
  - RESET has priority over FlushE.
- Decode, Op = Instr[27:26], Funct = Instr[25:20], cmd = Funct[4:1], S = Funct[0]:
  - Op = 00, cmd in {ADD 0100, SUB 0010, AND 0000, ORR 1100, MOV 1101}:
    - RegWrite = 1 and ALUControl = cmd.
    - ALUSrc = Funct[5] and ImmSrc = 00.
    - FlagWrite = S ? (arith ? 11 : 10) : 00, where 11 = NZCV and 10 = NZ only.
  - Op = 00, CMP (cmd 1010): RegWrite = 0, FlagWrite = 11 regardless of S, and ALUControl = SUB (0010).
  - Op = 00, BX (Instr[27:4] = 24'h12FFF1):
    - Branch = 1, ALUControl = MOV and ALUSrc = 0.
    - RegSrc = 00; the target is Rm.
  - Any other Op = 00 encoding is undefined.
  - Op = 01:
    - L = Funct[0]: LDR sets RegWrite = 1 and MemtoReg = 1; STR sets MemWrite = 1 and RegSrc[1] = 1.
    - Funct[5] = 0 selects the immediate offset: ALUSrc = 1, ImmSrc = 01.
    - Funct[5] = 1 selects the register offset: ALUSrc = 0. Undefined if REG_OFFSET_EN = 0.
    - U = Funct[3]: ALUControl = U ? ADD : SUB.
  - Op = 10:
    - Branch = 1, ImmSrc = 10, RegSrc[0] = 1, ALUSrc = 1 and ALUControl = ADD.
    - BL (Instr[24] = 1) also sets RegWrite = 1.
  - Op = 11 is undefined.
- Undefined instructions: UndefD = 1, and every write/branch/flag-write enable is 0.
- D->E register:
  - Captures the decoded controls and CondE = Instr[31:28] every cycle.
  - When FlushE = 1 it loads all-zero enables; CondE is don't-care.
- Execute:
  - CondExE follows the ARM table: EQ, NE, CS, CC, MI, PL, VS, VC, HI, LS, GE, LT, GT, LE, AL. Cond 1111 is never.
  - When COND_EN = 0, CondExE = 1.
  - BranchTakenE = BranchE & CondExE.
  - RegWrite and MemWrite are gated by CondExE before entering E->M.
  - Flag update at the edge ending the E cycle:
    - FlagWriteE[1] & CondExE loads N,Z.
    - FlagWriteE[0] & CondExE loads C,V.
  - Condition evaluation uses FlagsQ, the registered value. CMP followed immediately by Bcc therefore sees the new flags.
- Latency: an instruction in D at cycle n has its E controls valid at n+1, M controls at n+2, and W controls at n+3.
- E->M and M->W are plain registers with no stall. An external stall is realised by FlushE bubbles.

Test Plan:
- RESET for 2 cycles mid-stream with instructions in flight -> all registered outputs 0 and FlagsQ = 0000 on the next cycle; no residual RegWriteW.
- CMP R1,#5 (flags 0100 from the ALU) then BEQ in the next cycle -> FlagsQ = 0100 and BranchTakenE = 1. Repeat with BNE -> BranchTakenE = 0.
- ADDS writing NZCV = 1011, then ANDS with ALU flags 0100 -> FlagsQ = 1011, then 0111 (C and V preserved).
- LDR R2,[R3,-R4] -> ALUSrcE = 0 and ALUControlE = 0010; MemtoRegW = RegWriteW = 1 at cycle n+3. With REG_OFFSET_EN = 0 -> UndefD = 1 and no writes.
- ADDNE with Z = 1 -> RegWriteM = 0 at n+2 and no flag change. BL AL -> BranchTakenE = 1 and RegWriteW = 1 at n+3.
- Issue STR with FlushE = 1 in that cycle -> MemWriteM = 0 at n+2. Instr[27:26] = 11 -> UndefD = 1.
